// File: rtl/video_src_sched.sv
// Frame-aligned source scheduler for the video capture stream mux.
// Selects BT.656 (in1) or test pattern (in2); switches only on frame boundaries, with stall fallback.
module video_src_sched #(
  parameter int TOW = 24,
  parameter int LW  = 11,
  parameter int CW  = 16
) (
  input  logic           axi_clk_i,
  input  logic           axi_rstn_i,
  input  logic           req_sel_i,
  input  logic           fallback_en_i,
  input  logic [TOW-1:0] timeout_i,
  input  logic [LW-1:0]  frame_lines_i,
  input  logic           in1_tvalid_i,
  input  logic           in1_tready_i,
  input  logic           in1_tuser_i,
  input  logic           in1_tlast_i,
  input  logic           in2_tvalid_i,
  input  logic           in2_tready_i,
  input  logic           in2_tuser_i,
  input  logic           in2_tlast_i,
  input  logic           stall_clr_i,
  output logic           mux_sel_o,
  output logic           drop_o,
  output logic           switching_o,
  output logic           stall_o,
  output logic [CW-1:0]  switch_cnt_o
);

  typedef enum logic [1:0] {SYNC, RUN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic           mux_sel_q, mux_sel_d;
  logic           stall_q, stall_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]  lc_q, lc_d, lc_cnt;
  logic [TOW-1:0] wd_q, wd_d;
  logic           seen_q, seen_d, seen;

  logic sel_tvalid, sel_tready, sel_tuser, sel_tlast;
  logic sel_hs, sof, eol, eff, fb, trip;

  always_comb begin
    sel_tvalid = mux_sel_q ? in2_tvalid_i : in1_tvalid_i;
    sel_tready = mux_sel_q ? in2_tready_i : in1_tready_i;
    sel_tuser  = mux_sel_q ? in2_tuser_i  : in1_tuser_i;
    sel_tlast  = mux_sel_q ? in2_tlast_i  : in1_tlast_i;
  end

  assign sel_hs = sel_tvalid & sel_tready;
  assign sof    = sel_hs & sel_tuser;
  assign eol    = sel_hs & sel_tlast;
  assign eff    = stall_q | req_sel_i;

  // Boundary is judged on the post-beat line count so the final EOL cycle decides.
  always_comb begin
    lc_cnt = lc_q;
    if (sof)
      lc_cnt = eol ? LW'(1) : '0;
    else if (eol)
      lc_cnt = (lc_q >= frame_lines_i) ? frame_lines_i : lc_q + LW'(1);
  end

  assign seen = seen_q | sof;
  assign fb   = (lc_cnt >= frame_lines_i) || ((lc_cnt == '0) && !seen);
  assign trip = (timeout_i != '0) && (wd_q == timeout_i - TOW'(1)) &&
                !mux_sel_q && fallback_en_i;

  always_comb begin
    state_d   = state_q;
    mux_sel_d = mux_sel_q;
    cnt_d     = cnt_q;
    stall_d   = stall_clr_i ? 1'b0 : stall_q;
    unique case (state_q)
      SYNC: begin
        if (sof) begin
          state_d = RUN;
          cnt_d   = cnt_q + CW'(1);
        end else if (eff != mux_sel_q) begin
          mux_sel_d = eff;
        end
      end
      RUN: begin
        if (eff != mux_sel_q) begin
          if (fb) begin
            state_d   = SYNC;
            mux_sel_d = eff;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (eff == mux_sel_q) begin
          state_d = RUN;
        end else if (fb) begin
          state_d   = SYNC;
          mux_sel_d = eff;
        end
      end
      default: state_d = SYNC;
    endcase
    // Stall fallback abandons the current frame and overrides any pending decision.
    if (trip) begin
      stall_d   = 1'b1;
      mux_sel_d = 1'b1;
      state_d   = SYNC;
      cnt_d     = cnt_q;
    end
  end

  always_comb begin
    wd_d = wd_q + TOW'(1);
    if ((timeout_i == '0) || sel_hs || (state_d != state_q) || (mux_sel_d != mux_sel_q))
      wd_d = '0;
    lc_d   = (state_d == SYNC) ? '0   : lc_cnt;
    seen_d = (state_d == SYNC) ? 1'b0 : seen;
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state_q   <= SYNC;
      mux_sel_q <= 1'b0;
      stall_q   <= 1'b0;
      cnt_q     <= '0;
      lc_q      <= '0;
      wd_q      <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mux_sel_q <= mux_sel_d;
      stall_q   <= stall_d;
      cnt_q     <= cnt_d;
      lc_q      <= lc_d;
      wd_q      <= wd_d;
      seen_q    <= seen_d;
    end
  end

  assign mux_sel_o    = mux_sel_q;
  assign drop_o       = (state_q == SYNC) && !(sel_tvalid && sel_tuser);
  assign switching_o  = (state_q != RUN);
  assign stall_o      = stall_q;
  assign switch_cnt_o = cnt_q;

endmodule

// File: tb/tb_video_src_sched.sv
// Directed bench for video_src_sched: frame-aligned switching, drain cancel, watchdog fallback.
module tb_video_src_sched;
  localparam int TOW = 24;
  localparam int LW  = 11;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_sel = 1'b0, fallback_en = 1'b0, stall_clr = 1'b0;
  logic [TOW-1:0] timeout = '0;
  logic [LW-1:0]  frame_lines = LW'(4);
  logic           in1_tvalid = 1'b0, in1_tuser = 1'b0, in1_tlast = 1'b0;
  logic           in2_tvalid = 1'b0, in2_tuser = 1'b0, in2_tlast = 1'b0;
  logic           mux_sel, drop, switching, stall;
  logic [CW-1:0]  switch_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_src_sched #(.TOW(TOW), .LW(LW), .CW(CW)) dut (
    .axi_clk_i(clk), .axi_rstn_i(rst_n),
    .req_sel_i(req_sel), .fallback_en_i(fallback_en),
    .timeout_i(timeout), .frame_lines_i(frame_lines),
    .in1_tvalid_i(in1_tvalid), .in1_tready_i(1'b1), .in1_tuser_i(in1_tuser), .in1_tlast_i(in1_tlast),
    .in2_tvalid_i(in2_tvalid), .in2_tready_i(1'b1), .in2_tuser_i(in2_tuser), .in2_tlast_i(in2_tlast),
    .stall_clr_i(stall_clr),
    .mux_sel_o(mux_sel), .drop_o(drop), .switching_o(switching),
    .stall_o(stall), .switch_cnt_o(switch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input bit src, input bit u, input bit l);
    in1_tvalid = !src; in1_tuser = u; in1_tlast = l;
    in2_tvalid = src;  in2_tuser = u; in2_tlast = l;
  endtask

  task automatic tx(input bit src, input bit u, input bit l);
    set_beat(src, u, l);
    cyc();
  endtask

  task automatic idle(input int n);
    in1_tvalid = 1'b0;
    in2_tvalid = 1'b0;
    repeat (n) cyc();
  endtask

  // Two beats per line, tlast on the second.
  task automatic lines(input bit src, input int n);
    repeat (n) begin
      tx(src, 1'b0, 1'b0);
      tx(src, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #1;
    check("rst_mux", mux_sel, 0);
    check("rst_stall", stall, 0);
    check("rst_cnt", switch_cnt, 0);
    check("rst_switching", switching, 1);
    check("rst_drop", drop, 1);
    in1_tvalid = 1'b1; in1_tuser = 1'b1;
    #1;
    check("rst_drop_sof", drop, 0);
    in1_tvalid = 1'b0; in1_tuser = 1'b0;
    #1 rst_n = 1'b1;
    cyc();

    // Junk beats dropped until SOF, SOF passes and enters RUN
    for (int i = 0; i < 5; i++) begin
      set_beat(1'b0, 1'b0, i == 2);
      #1;
      check("t1_junk_drop", drop, 1);
      cyc();
    end
    set_beat(1'b0, 1'b1, 1'b0);
    #1;
    check("t1_sof_drop", drop, 0);
    cyc();
    check("t1_run", switching, 0);
    check("t1_cnt", switch_cnt, 1);
    tx(1'b0, 1'b0, 1'b1);
    lines(1'b0, 3);

    // Request in2 after line 2: drain, switch on 4th EOL
    tx(1'b0, 1'b1, 1'b0);
    tx(1'b0, 1'b0, 1'b1);
    lines(1'b0, 1);
    req_sel = 1'b1;
    idle(1);
    check("t2_drain_sw", switching, 1);
    check("t2_drain_mux", mux_sel, 0);
    lines(1'b0, 1);
    tx(1'b0, 1'b0, 1'b0);
    set_beat(1'b0, 1'b0, 1'b1);
    #1;
    check("t2_last_mux", mux_sel, 0);
    check("t2_last_drop", drop, 0);
    cyc();
    check("t2_switch_mux", mux_sel, 1);
    check("t2_switch_sw", switching, 1);
    set_beat(1'b1, 1'b0, 1'b1);
    #1;
    check("t2_in2_junk_drop", drop, 1);
    cyc();
    set_beat(1'b1, 1'b1, 1'b0);
    #1;
    check("t2_in2_sof_drop", drop, 0);
    cyc();
    check("t2_cnt", switch_cnt, 2);
    check("t2_run", switching, 0);
    tx(1'b1, 1'b0, 1'b1);
    lines(1'b1, 3);

    // Drain cancelled by request returning
    tx(1'b1, 1'b1, 1'b0);
    tx(1'b1, 1'b0, 1'b1);
    req_sel = 1'b0;
    idle(1);
    check("t3_drain_sw", switching, 1);
    check("t3_drain_mux", mux_sel, 1);
    req_sel = 1'b1;
    idle(1);
    check("t3_back_run", switching, 0);
    check("t3_mux", mux_sel, 1);
    check("t3_cnt", switch_cnt, 2);
    lines(1'b1, 3);
    req_sel = 1'b0;
    idle(1);
    check("t3_fb_switch_mux", mux_sel, 0);
    check("t3_fb_switch_sw", switching, 1);
    tx(1'b0, 1'b1, 1'b0);
    check("t3_cnt3", switch_cnt, 3);
    tx(1'b0, 1'b0, 1'b1);

    // Watchdog disabled: no reaction to a long stall
    timeout = '0; fallback_en = 1'b1;
    idle(2000);
    check("t5_to0_sw", switching, 0);
    check("t5_to0_stall", stall, 0);
    timeout = TOW'(100); fallback_en = 1'b0;
    idle(2000);
    check("t5_fb0_sw", switching, 0);
    check("t5_fb0_stall", stall, 0);
    check("t5_fb0_mux", mux_sel, 0);

    // Watchdog trip on the 100th idle cycle
    fallback_en = 1'b1;
    tx(1'b0, 1'b0, 1'b0);
    idle(99);
    check("t4_pre_stall", stall, 0);
    check("t4_pre_mux", mux_sel, 0);
    idle(1);
    check("t4_trip_stall", stall, 1);
    check("t4_trip_mux", mux_sel, 1);
    check("t4_trip_sw", switching, 1);
    idle(5);
    check("t4_req_ignored", mux_sel, 1);
    tx(1'b1, 1'b1, 1'b0);
    check("t4_in2_cnt", switch_cnt, 4);
    check("t4_in2_run", switching, 0);
    tx(1'b1, 1'b0, 1'b1);
    stall_clr = 1'b1;
    idle(1);
    stall_clr = 1'b0;
    check("t4_clr_stall", stall, 0);
    idle(1);
    check("t4_clr_drain", switching, 1);
    check("t4_clr_mux", mux_sel, 1);
    lines(1'b1, 2);
    tx(1'b1, 1'b0, 1'b0);
    set_beat(1'b1, 1'b0, 1'b1);
    #1;
    check("t4_last_mux", mux_sel, 1);
    cyc();
    check("t4_back_mux", mux_sel, 0);
    tx(1'b0, 1'b1, 1'b0);
    check("t4_back_cnt", switch_cnt, 5);

    // Clear coinciding with trip: set wins
    idle(99);
    stall_clr = 1'b1;
    idle(1);
    stall_clr = 1'b0;
    check("t6_stall", stall, 1);
    check("t6_mux", mux_sel, 1);
    check("t6_sw", switching, 1);

    // Asynchronous reset mid-frame
    tx(1'b1, 1'b1, 1'b0);
    check("t7_pre_cnt", switch_cnt, 6);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_mux", mux_sel, 0);
    check("t7_rst_cnt", switch_cnt, 0);
    check("t7_rst_stall", stall, 0);
    check("t7_rst_sw", switching, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
